eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, AXIS data width in bits (32 or 64).
REQ-002 SHALL have parameter IFG_CYCLES, default 2, idle cycles inserted after each frame when ETH_TX_ARB_IFG_EN is defined.
REQ-003 SHALL have ports:
clk  input  1  single clock
rstn  input  1  asynchronous active-low reset
s0_tdata / s1_tdata  input  AXIS_DATA_WIDTH  source payload
s0_tkeep / s1_tkeep  input  AXIS_DATA_WIDTH/8  byte enables
s0_tvalid / s1_tvalid  input  1  source valid
s0_tlast / s1_tlast  input  1  end of frame
s0_tuser / s1_tuser  input  1  sideband, passed through
s0_tready / s1_tready  output  1  source ready
s0_remote_addr / s1_remote_addr  input  48  destination MAC per source
s0_tx_size / s1_tx_size  input  16  length/type per source
m_tdata  output  AXIS_DATA_WIDTH  to frame generator
m_tkeep  output  AXIS_DATA_WIDTH/8  to frame generator
m_tvalid  output  1  to frame generator
m_tlast  output  1  to frame generator
m_tuser  output  1  to frame generator
m_tready  input  1  from frame generator
m_remote_addr  output  48  latched destination for current frame
m_tx_size  output  16  latched length for current frame
grant  output  2  one-hot active source, 0 when idle
s0_frm_cnt / s1_frm_cnt  output  16  completed frames per source

Function
REQ-004 SHALL implement FSM states IDLE, GNT0, GNT1, GAP; reset state IDLE.
REQ-005 IDLE: if exactly one sX_tvalid high, SHALL move to GNTX next cycle; if both high, SHALL grant the source not granted last (round-robin); initial last-granted = s1 so s0 wins first tie.
REQ-006 On entering GNTX SHALL register sX_remote_addr and sX_tx_size into m_remote_addr / m_tx_size and hold them constant until the next grant.
REQ-007 In GNTX: m_tdata/tkeep/tlast/tuser/tvalid SHALL combinationally equal sX signals; sX_tready = m_tready; other source tready = 0.
REQ-008 In IDLE and GAP: m_tvalid = 0 and both s_tready = 0.
REQ-009 Grant SHALL lock for a whole frame; exit only on m_tvalid & m_tready & m_tlast.
REQ-010 On that tlast beat: sX_frm_cnt SHALL increment by 1, wrapping 0xFFFF -> 0x0000; last-granted := X; next state GAP if ETH_TX_ARB_IFG_EN else IDLE.
REQ-011 Arbitration latency: first beat of a frame SHALL be presentable on m_* exactly 1 cycle after sX_tvalid rises in IDLE; back-to-back frames SHALL have at least 1 idle cycle between them.
REQ-012 sX_tvalid deasserting mid-frame SHALL NOT release the grant; m_tvalid follows it low.
REQ-013 tlast with m_tready low SHALL NOT end the frame; beat is held until accepted.
REQ-014 grant SHALL be 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 otherwise.

Reset
REQ-015 While rstn low: state IDLE, grant 0, m_tvalid 0, s0/s1_tready 0, m_remote_addr 0, m_tx_size 0, frm counters 0, last-granted s1, GAP counter 0.
REQ-016 Reset asserted mid-frame SHALL abort immediately; after release no partial-frame state remains and arbitration restarts from IDLE.

Configuration
REQ-017 Macro ETH_TX_ARB_IFG_EN defined: after every frame SHALL stay in GAP for exactly IFG_CYCLES cycles (counter 0..IFG_CYCLES-1), then IDLE; IFG_CYCLES = 0 behaves as undefined.
REQ-018 Macro undefined: GAP state and counter SHALL be absent; tlast acceptance returns directly to IDLE.

Verification
REQ-019 Single source: s0 sends 3-beat frame, remote_addr 0x001122334455, tx_size 0x0800, m_tready=1 -> grant=01 one cycle after valid, 3 beats on m_*, m_remote_addr=0x001122334455, s0_frm_cnt=1.
REQ-020 Contention: s0 and s1 both valid continuously, 2-beat frames -> grants alternate 01,10,01,10 with >=1 idle cycle between frames.
REQ-021 Backpressure: m_tready toggles every cycle during s1 frame with tlast on beat 4 -> all 4 beats delivered once, s0 tready stays 0, grant held until tlast accepted.
REQ-022 Reset mid-frame: rstn low on beat 2 of s0 frame -> all outputs at REQ-015 values; after release s1 valid gets grant 10 next cycle.
REQ-023 Counter wrap: preload 65535 s0 frames (or force) then one more -> s0_frm_cnt = 0x0000.
REQ-024 With ETH_TX_ARB_IFG_EN, IFG_CYCLES=2: back-to-back s0 frames -> exactly 2 GAP cycles plus 1 IDLE cycle between tlast and next first beat.

Source files
------------

// File: rtl/eth_tx_arb_if.sv
// rtl/eth_tx_arb_if.sv - stream channel carrying one frame plus its destination/length sideband
//
// Signals: tdata/tkeep/tvalid/tlast/tuser/tready form the beat handshake;
// remote_addr (48b destination MAC) and tx_size (16b length/type) describe the frame.
// master: the side that produces beats; slave: the side that accepts them.
interface eth_tx_arb_if #(
    parameter int AXIS_DATA_WIDTH = 64
);
    logic [AXIS_DATA_WIDTH-1:0]   tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic                         tvalid;
    logic                         tlast;
    logic                         tuser;
    logic                         tready;
    logic [47:0]                  remote_addr;
    logic [15:0]                  tx_size;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser, remote_addr, tx_size,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser, remote_addr, tx_size,
        output tready
    );
endinterface

// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - two-source round-robin frame arbiter in front of an Ethernet frame generator
//
// Ports:
//   clk, rstn         single clock, asynchronous active-low reset
//   s0, s1            slave channels from the two frame sources
//   m                 master channel to the frame generator; remote_addr/tx_size are the
//                     values latched when the current frame was granted
//   grant             one-hot active source (01 = s0, 10 = s1), 00 when no frame is granted
//   s0/s1_frm_cnt     completed frames per source, wrapping at 16 bits
// Optional feature: define ETH_TX_ARB_IFG_EN to insert IFG_CYCLES idle (GAP) cycles after
// every frame; without it the arbiter returns straight to IDLE after the last beat.
module eth_tx_arb #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int IFG_CYCLES      = 2
) (
    input  logic               clk,
    input  logic               rstn,
    eth_tx_arb_if.slave        s0,
    eth_tx_arb_if.slave        s1,
    eth_tx_arb_if.master       m,
    output logic [1:0]         grant,
    output logic [15:0]        s0_frm_cnt,
    output logic [15:0]        s1_frm_cnt
);

`ifdef ETH_TX_ARB_IFG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, GAP = 2'd3} state_t;
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic        last_q, last_d;        // 1: s1 was granted most recently
    logic [47:0] addr_q, addr_d;
    logic [15:0] size_q, size_d;
    logic [15:0] s0_cnt_q, s0_cnt_d;
    logic [15:0] s1_cnt_q, s1_cnt_d;
`ifdef ETH_TX_ARB_IFG_EN
    logic [GW-1:0] gap_q, gap_d;
`endif

    logic s0_end;
    logic s1_end;

    // The frame ends only when its last beat is actually accepted downstream.
    assign s0_end = (state_q == GNT0) && s0.tvalid && m.tready && s0.tlast;
    assign s1_end = (state_q == GNT1) && s1.tvalid && m.tready && s1.tlast;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            addr_q   <= '0;
            size_q   <= '0;
            s0_cnt_q <= '0;
            s1_cnt_q <= '0;
`ifdef ETH_TX_ARB_IFG_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            s0_cnt_q <= s0_cnt_d;
            s1_cnt_q <= s1_cnt_d;
`ifdef ETH_TX_ARB_IFG_EN
            gap_q    <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        size_d   = size_q;
        s0_cnt_d = s0_cnt_q;
        s1_cnt_d = s1_cnt_q;
`ifdef ETH_TX_ARB_IFG_EN
        gap_d    = gap_q;
`endif
        case (state_q)
            IDLE: begin
                // On a tie the source that was not served last wins.
                if (s0.tvalid && (!s1.tvalid || last_q)) begin
                    state_d = GNT0;
                    addr_d  = s0.remote_addr;
                    size_d  = s0.tx_size;
                end else if (s1.tvalid) begin
                    state_d = GNT1;
                    addr_d  = s1.remote_addr;
                    size_d  = s1.tx_size;
                end
            end
            GNT0: begin
                if (s0_end) begin
                    s0_cnt_d = s0_cnt_q + 16'd1;
                    last_d   = 1'b0;
                    state_d  = IDLE;
`ifdef ETH_TX_ARB_IFG_EN
                    if (IFG_CYCLES > 0) state_d = GAP;
`endif
                end
            end
            GNT1: begin
                if (s1_end) begin
                    s1_cnt_d = s1_cnt_q + 16'd1;
                    last_d   = 1'b1;
                    state_d  = IDLE;
`ifdef ETH_TX_ARB_IFG_EN
                    if (IFG_CYCLES > 0) state_d = GAP;
`endif
                end
            end
`ifdef ETH_TX_ARB_IFG_EN
            GAP: begin
                if (gap_q == GW'(IFG_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Data path is a pure mux: the granted source sees the generator's tready directly.
    always_comb begin
        m.tdata   = '0;
        m.tkeep   = '0;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        m.tuser   = 1'b0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        grant     = 2'b00;
        case (state_q)
            GNT0: begin
                m.tdata   = s0.tdata;
                m.tkeep   = s0.tkeep;
                m.tvalid  = s0.tvalid;
                m.tlast   = s0.tlast;
                m.tuser   = s0.tuser;
                s0.tready = m.tready;
                grant     = 2'b01;
            end
            GNT1: begin
                m.tdata   = s1.tdata;
                m.tkeep   = s1.tkeep;
                m.tvalid  = s1.tvalid;
                m.tlast   = s1.tlast;
                m.tuser   = s1.tuser;
                s1.tready = m.tready;
                grant     = 2'b10;
            end
            default: ;
        endcase
    end

    assign m.remote_addr = addr_q;
    assign m.tx_size     = size_q;
    assign s0_frm_cnt    = s0_cnt_q;
    assign s1_frm_cnt    = s1_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - self-checking bench for eth_tx_arb with a behavioural arbiter model
module tb_eth_tx_arb;
    localparam int DW  = 64;
    localparam int IFG = 2;
`ifdef ETH_TX_ARB_IFG_EN
    localparam int GAPC = IFG;
`else
    localparam int GAPC = 0;
`endif

    logic        clk;
    logic        rstn;
    logic [1:0]  grant;
    logic [15:0] s0_frm_cnt, s1_frm_cnt;

    eth_tx_arb_if #(.AXIS_DATA_WIDTH(DW)) s0_if ();
    eth_tx_arb_if #(.AXIS_DATA_WIDTH(DW)) s1_if ();
    eth_tx_arb_if #(.AXIS_DATA_WIDTH(DW)) m_if ();

    eth_tx_arb #(.AXIS_DATA_WIDTH(DW), .IFG_CYCLES(IFG)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s0         (s0_if.slave),
        .s1         (s1_if.slave),
        .m          (m_if.master),
        .grant      (grant),
        .s0_frm_cnt (s0_frm_cnt),
        .s1_frm_cnt (s1_frm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus state ----------------
    logic [DW-1:0] d [2];
    logic [7:0]    k [2];
    logic          v [2];
    logic          l [2];
    logic          u [2];
    logic [47:0]   a [2];
    logic [15:0]   z [2];
    logic          mr;
    int            left [2];
    bit            acc [2];
    bit            macc;
    logic [DW-1:0] mdata;
    logic          mlast;
    int            gseq [$];
    int            sw_bad;

    task automatic apply();
        s0_if.tdata = d[0]; s0_if.tkeep = k[0]; s0_if.tvalid = v[0]; s0_if.tlast = l[0];
        s0_if.tuser = u[0]; s0_if.remote_addr = a[0]; s0_if.tx_size = z[0];
        s1_if.tdata = d[1]; s1_if.tkeep = k[1]; s1_if.tvalid = v[1]; s1_if.tlast = l[1];
        s1_if.tuser = u[1]; s1_if.remote_addr = a[1]; s1_if.tx_size = z[1];
        m_if.tready = mr;
    endtask

    // Captures handshakes of the coming edge (inputs are stable from negedge to posedge).
    task automatic tick();
        @(negedge clk);
        acc[0] = s0_if.tvalid && s0_if.tready;
        acc[1] = s1_if.tvalid && s1_if.tready;
        macc   = m_if.tvalid && m_if.tready;
        mdata  = m_if.tdata;
        mlast  = m_if.tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; l[i] = 1'b0; d[i] = '0; k[i] = 8'hFF; u[i] = 1'b0;
            a[i] = '0; z[i] = '0; left[i] = 0;
        end
        mr = 1'b1;
        apply();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic rand_run(input int cycles, input int vpct, input int rpct,
                            input int minlen, input int maxlen, input bit en0, input bit en1);
        bit en [2];
        logic [1:0] pg;
        en[0] = en0; en[1] = en1;
        pg = grant;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (grant != 2'b00 && grant != pg) begin
                gseq.push_back(int'(grant));
                if (pg != 2'b00) sw_bad++;
            end
            pg = grant;
            for (int i = 0; i < 2; i++) begin
                if (v[i] && acc[i]) begin
                    if (l[i]) left[i] = 0; else left[i] = left[i] - 1;
                    v[i] = 1'b0;
                end
                // Valid may drop between beats of a frame; a pending beat is never withdrawn.
                if (!v[i] && en[i] && ($urandom % 100) < vpct) begin
                    if (left[i] == 0) left[i] = int'($urandom_range(maxlen, minlen));
                    v[i] = 1'b1;
                    d[i] = {$urandom, $urandom};
                    k[i] = 8'($urandom);
                    u[i] = 1'($urandom);
                    l[i] = (left[i] == 1);
                end
                // Destination changes every cycle so latching on the grant edge is exercised.
                a[i] = {16'($urandom), $urandom};
                z[i] = 16'($urandom);
            end
            mr = (($urandom % 100) < rpct);
            apply();
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    int          m_own;      // 0 none, 1 s0, 2 s1
    int          m_gap;      // idle cycles still owed after a frame
    int          m_last;     // index of most recently served source
    logic [15:0] m_cnt [2];
    logic [47:0] m_addr;
    logic [15:0] m_size;

    task automatic model_reset();
        m_own = 0; m_gap = 0; m_last = 1;
        m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
        m_addr = '0; m_size = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rstn) model_reset();
            if (chk_en) begin
                chk("grant", grant, (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00);
                chk("m_remote_addr", m_if.remote_addr, m_addr);
                chk("m_tx_size", m_if.tx_size, m_size);
                chk("s0_frm_cnt", s0_frm_cnt, m_cnt[0]);
                chk("s1_frm_cnt", s1_frm_cnt, m_cnt[1]);
                if (m_own == 1) begin
                    chk("m_tvalid", m_if.tvalid, s0_if.tvalid);
                    chk("m_tdata", m_if.tdata, s0_if.tdata);
                    chk("m_tkeep", m_if.tkeep, s0_if.tkeep);
                    chk("m_tlast", m_if.tlast, s0_if.tlast);
                    chk("m_tuser", m_if.tuser, s0_if.tuser);
                    chk("s0_tready", s0_if.tready, m_if.tready);
                    chk("s1_tready", s1_if.tready, 1'b0);
                end else if (m_own == 2) begin
                    chk("m_tvalid", m_if.tvalid, s1_if.tvalid);
                    chk("m_tdata", m_if.tdata, s1_if.tdata);
                    chk("m_tkeep", m_if.tkeep, s1_if.tkeep);
                    chk("m_tlast", m_if.tlast, s1_if.tlast);
                    chk("m_tuser", m_if.tuser, s1_if.tuser);
                    chk("s0_tready", s0_if.tready, 1'b0);
                    chk("s1_tready", s1_if.tready, m_if.tready);
                end else begin
                    chk("m_tvalid", m_if.tvalid, 1'b0);
                    chk("s0_tready", s0_if.tready, 1'b0);
                    chk("s1_tready", s1_if.tready, 1'b0);
                end
            end
            if (rstn) begin
                if (m_own != 0) begin
                    bit sv, sl;
                    sv = (m_own == 1) ? s0_if.tvalid : s1_if.tvalid;
                    sl = (m_own == 1) ? s0_if.tlast  : s1_if.tlast;
                    if (sv && m_if.tready && sl) begin
                        m_cnt[m_own-1] = m_cnt[m_own-1] + 16'd1;
                        m_last = m_own - 1;
                        m_own  = 0;
                        m_gap  = GAPC;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else begin
                    if (s0_if.tvalid && s1_if.tvalid) m_own = (m_last == 1) ? 1 : 2;
                    else if (s0_if.tvalid)            m_own = 1;
                    else if (s1_if.tvalid)            m_own = 2;
                    if (m_own == 1) begin m_addr = s0_if.remote_addr; m_size = s0_if.tx_size; end
                    if (m_own == 2) begin m_addr = s1_if.remote_addr; m_size = s1_if.tx_size; end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed + random sequences ----------------
    logic [DW-1:0] dd [4];
    logic [DW-1:0] seen [4];
    int bi, nb, viol, n;

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Reset state
        chk("rst_grant", grant, 2'b00);
        chk("rst_addr", m_if.remote_addr, 48'h0);
        chk("rst_cnt0", s0_frm_cnt, 16'h0);

        // Single source, 3 beats
        a[0] = 48'h001122334455; z[0] = 16'h0800; d[0] = 64'hA0; l[0] = 1'b0; v[0] = 1'b1;
        apply();
        chk("r19_grant_pre", grant, 2'b00);
        tick();
        chk("r19_grant", grant, 2'b01);
        chk("r19_addr", m_if.remote_addr, 48'h001122334455);
        chk("r19_size", m_if.tx_size, 16'h0800);
        a[0] = 48'hFFFFFFFFFFFF; z[0] = 16'h1234; apply();
        tick();
        chk("r19_beat0", mdata, 64'hA0);
        d[0] = 64'hA1; apply();
        tick();
        chk("r19_beat1", mdata, 64'hA1);
        d[0] = 64'hA2; l[0] = 1'b1; apply();
        tick();
        chk("r19_beat2", mdata, 64'hA2);
        chk("r19_last", mlast, 1'b1);
        v[0] = 1'b0; apply();
        chk("r19_cnt", s0_frm_cnt, 16'd1);
        chk("r19_addr_hold", m_if.remote_addr, 48'h001122334455);

        // Contention, 2-beat frames
        do_reset();
        gseq.delete(); sw_bad = 0;
        rand_run(20, 100, 100, 2, 2, 1'b1, 1'b1);
        chk("r20_nframes_ge4", (gseq.size() >= 4), 1'b1);
        if (gseq.size() >= 4) begin
            chk("r20_g0", gseq[0], 1);
            chk("r20_g1", gseq[1], 2);
            chk("r20_g2", gseq[2], 1);
            chk("r20_g3", gseq[3], 2);
        end
        chk("r20_no_direct_switch", sw_bad, 0);

        // Backpressure on a 4-beat s1 frame
        do_reset();
        dd[0] = 64'hB0; dd[1] = 64'hB1; dd[2] = 64'hB2; dd[3] = 64'hB3;
        d[1] = dd[0]; l[1] = 1'b0; v[1] = 1'b1; mr = 1'b0; apply();
        tick();
        chk("r21_grant", grant, 2'b10);
        v[0] = 1'b1; d[0] = 64'hC0; l[0] = 1'b1; mr = 1'b1; apply();
        bi = 0; nb = 0; viol = 0;
        for (int c = 0; c < 30 && bi < 4; c++) begin
            tick();
            if (macc) begin
                if (nb < 4) seen[nb] = mdata;
                nb++;
            end
            if (acc[1]) begin
                bi++;
                if (bi < 4) begin d[1] = dd[bi]; l[1] = (bi == 3); end
                else v[1] = 1'b0;
            end
            if (bi < 4 && (grant != 2'b10 || s0_if.tready)) viol++;
            mr = !mr;
            apply();
        end
        chk("r21_beats_done", bi, 4);
        chk("r21_beats_on_m", nb, 4);
        for (int i = 0; i < 4; i++) chk("r21_beat_data", seen[i], dd[i]);
        chk("r21_grant_held", viol, 0);
        chk("r21_s1_cnt", s1_frm_cnt, 16'd1);

        // Reset on beat 2 of an s0 frame
        do_reset();
        d[0] = 64'hD0; l[0] = 1'b0; v[0] = 1'b1; a[0] = 48'hABCDEF012345; z[0] = 16'h0806;
        apply();
        tick();
        tick();
        d[0] = 64'hD1; apply();
        rstn = 1'b0;
        #1;
        chk("r22_grant", grant, 2'b00);
        chk("r22_tvalid", m_if.tvalid, 1'b0);
        chk("r22_s0_tready", s0_if.tready, 1'b0);
        chk("r22_s1_tready", s1_if.tready, 1'b0);
        chk("r22_addr", m_if.remote_addr, 48'h0);
        chk("r22_size", m_if.tx_size, 16'h0);
        v[0] = 1'b0; v[1] = 1'b1; d[1] = 64'hE0; l[1] = 1'b1; apply();
        tick();
        rstn = 1'b1;
        tick();
        chk("r22_regrant", grant, 2'b10);

        // Back-to-back single-beat s0 frames: idle cycles between frames
        do_reset();
        d[0] = 64'hF0; l[0] = 1'b1; v[0] = 1'b1; apply();
        tick();
        tick();
        chk("ifg_first_accept", acc[0], 1'b1);
        d[0] = 64'hF1; apply();
        n = 0;
        while (!m_if.tvalid && n < 10) begin
            n++;
            tick();
        end
        chk("ifg_idle_cycles", n, 1 + GAPC);

        // Randomized traffic
        do_reset();
        rand_run(800, 70, 60, 1, 4, 1'b1, 1'b1);
        rand_run(600, 95, 25, 1, 5, 1'b1, 1'b1);
        rand_run(300, 50, 100, 1, 3, 1'b1, 1'b0);
        rand_run(300, 50, 80, 1, 3, 1'b0, 1'b1);

        // Frame counter wrap
        do_reset();
        force dut.s0_cnt_q = 16'hFFFF;
        m_cnt[0] = 16'hFFFF;
        tick();
        release dut.s0_cnt_q;
        tick();
        chk("wrap_pre", s0_frm_cnt, 16'hFFFF);
        d[0] = 64'h77; l[0] = 1'b1; v[0] = 1'b1; apply();
        tick();
        tick();
        v[0] = 1'b0; apply();
        chk("wrap_cnt", s0_frm_cnt, 16'h0000);
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
